// File: rtl/download_packer_pkg.sv
// Shared types and helpers for the download packer.
// State enum, word/lane widths and the default DDR base address.
package download_packer_pkg;

    localparam int LANE_W = 2;
    localparam int WIDX_W = 22;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;

    typedef enum logic [1:0] {
        FILL,
        FLUSH,
        DONE
    } state_e;

    function automatic logic [31:0] word_addr(
        input logic [31:0]       base,
        input logic [WIDX_W-1:0] idx
    );
        return base + {7'd0, idx, 3'b000};
    endfunction

    function automatic logic [63:0] lane_data(
        input logic [LANE_W-1:0] lane,
        input logic [15:0]       hw
    );
        return {48'd0, hw} << {lane, 4'b0000};
    endfunction

    function automatic logic [7:0] lane_mask(
        input logic [LANE_W-1:0] lane
    );
        return 8'b0000_0011 << {lane, 1'b0};
    endfunction

endpackage

// File: rtl/download_packer_ddr_write_slot.sv
// One-entry DDR write request register (module ddr_write_slot).
// Holds address/data/mask stable until the DDR side accepts.
module ddr_write_slot
    import download_packer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        load_vld,
    input  logic [31:0] load_addr,
    input  logic [63:0] load_data,
    input  logic [7:0]  load_mask,
    input  logic        ddr_wait_req,
    output logic        accept,
    output logic        ddr_wr,
    output logic [31:0] ddr_addr,
    output logic [63:0] ddr_din,
    output logic [7:0]  ddr_mask
);

    logic        vld_q, vld_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] data_q, data_d;
    logic [7:0]  mask_q, mask_d;

    assign accept = vld_q & ~ddr_wait_req;

    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        data_d = data_q;
        mask_d = mask_q;
        if (load_vld) begin
            vld_d  = 1'b1;
            addr_d = load_addr;
            data_d = load_data;
            mask_d = load_mask;
        end else if (accept) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            vld_q  <= 1'b0;
            addr_q <= BASE_ADDR;
            data_q <= '0;
            mask_q <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            data_q <= data_d;
            mask_q <= mask_d;
        end
    end

    assign ddr_wr   = vld_q;
    assign ddr_addr = addr_q;
    assign ddr_din  = data_q;
    assign ddr_mask = mask_q;

endmodule

// File: rtl/download_packer.sv
// Packs 16-bit download halfwords into masked 64-bit DDR writes.
// Optional checksum output: define DOWNLOAD_CHECKSUM_EN.
module download_packer
    import download_packer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dl_cs,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [15:0] dl_dout,
    output logic        dl_wait,
    output logic        ddr_wr,
    output logic [31:0] ddr_addr,
    output logic [63:0] ddr_din,
    output logic [7:0]  ddr_mask,
    input  logic        ddr_wait_req,
    output logic        done
`ifdef DOWNLOAD_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    state_e              state_q, state_d;
    logic                cs_q;
    logic [63:0]         buf_data_q, buf_data_d;
    logic [7:0]          buf_mask_q, buf_mask_d;
    logic [WIDX_W-1:0]   buf_idx_q, buf_idx_d;
    logic                pend_vld_q, pend_vld_d;
    logic [WIDX_W-1:0]   pend_idx_q, pend_idx_d;
    logic [LANE_W-1:0]   pend_lane_q, pend_lane_d;
    logic [15:0]         pend_hw_q, pend_hw_d;
    logic                end_q, end_d;

    logic [WIDX_W-1:0]   w_idx;
    logic [LANE_W-1:0]   w_lane;
    logic                acc_wr, buf_empty, same_word;
    logic                sess_fall, sess_rise;
    logic [63:0]         mrg_data;
    logic [7:0]          mrg_mask;
    logic                ld_vld, slot_accept;
    logic [WIDX_W-1:0]   ld_idx;
    logic [63:0]         ld_data;
    logic [7:0]          ld_mask;
    logic                addr_lsb_unused;

    assign addr_lsb_unused = dl_addr[0];
    assign w_idx     = dl_addr[24:3];
    assign w_lane    = dl_addr[2:1];
    assign acc_wr    = dl_wr & (state_q == FILL);
    assign buf_empty = (buf_mask_q == 8'd0);
    assign same_word = buf_empty | (w_idx == buf_idx_q);
    assign sess_fall = cs_q & ~dl_cs;
    assign sess_rise = ~cs_q & dl_cs;
    assign mrg_data  = (buf_data_q & ~lane_data(w_lane, 16'hFFFF))
                     | lane_data(w_lane, dl_dout);
    assign mrg_mask  = buf_mask_q | lane_mask(w_lane);

    always_comb begin
        state_d     = state_q;
        buf_data_d  = buf_data_q;
        buf_mask_d  = buf_mask_q;
        buf_idx_d   = buf_idx_q;
        pend_vld_d  = pend_vld_q;
        pend_idx_d  = pend_idx_q;
        pend_lane_d = pend_lane_q;
        pend_hw_d   = pend_hw_q;
        end_d       = end_q;
        ld_vld      = 1'b0;
        ld_idx      = buf_idx_q;
        ld_data     = buf_data_q;
        ld_mask     = buf_mask_q;
        unique case (state_q)
            FILL: begin
                if (acc_wr && same_word) begin
                    if (mrg_mask[7:6] != 2'b00 || sess_fall) begin
                        ld_vld     = 1'b1;
                        ld_idx     = w_idx;
                        ld_data    = mrg_data;
                        ld_mask    = mrg_mask;
                        buf_data_d = '0;
                        buf_mask_d = '0;
                        state_d    = FLUSH;
                        end_d      = sess_fall;
                    end else begin
                        buf_data_d = mrg_data;
                        buf_mask_d = mrg_mask;
                        buf_idx_d  = w_idx;
                    end
                end else if (acc_wr) begin
                    // Word change: flush the old word, park the new halfword
                    ld_vld      = 1'b1;
                    pend_vld_d  = 1'b1;
                    pend_idx_d  = w_idx;
                    pend_lane_d = w_lane;
                    pend_hw_d   = dl_dout;
                    buf_data_d  = '0;
                    buf_mask_d  = '0;
                    state_d     = FLUSH;
                    end_d       = sess_fall;
                end else if (sess_fall) begin
                    if (buf_empty) begin
                        state_d = DONE;
                    end else begin
                        ld_vld     = 1'b1;
                        buf_data_d = '0;
                        buf_mask_d = '0;
                        state_d    = FLUSH;
                        end_d      = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (sess_fall) end_d = 1'b1;
                if (slot_accept) begin
                    if (pend_vld_q) begin
                        pend_vld_d = 1'b0;
                        if (pend_lane_q == 2'd3 || end_d) begin
                            ld_vld  = 1'b1;
                            ld_idx  = pend_idx_q;
                            ld_data = lane_data(pend_lane_q, pend_hw_q);
                            ld_mask = lane_mask(pend_lane_q);
                        end else begin
                            buf_data_d = lane_data(pend_lane_q, pend_hw_q);
                            buf_mask_d = lane_mask(pend_lane_q);
                            buf_idx_d  = pend_idx_q;
                            state_d    = FILL;
                        end
                    end else if (end_d) begin
                        end_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            DONE: begin
                end_d   = 1'b0;
                state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            cs_q        <= 1'b0;
            buf_data_q  <= '0;
            buf_mask_q  <= '0;
            buf_idx_q   <= '0;
            pend_vld_q  <= 1'b0;
            pend_idx_q  <= '0;
            pend_lane_q <= '0;
            pend_hw_q   <= '0;
            end_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cs_q        <= dl_cs;
            buf_data_q  <= buf_data_d;
            buf_mask_q  <= buf_mask_d;
            buf_idx_q   <= buf_idx_d;
            pend_vld_q  <= pend_vld_d;
            pend_idx_q  <= pend_idx_d;
            pend_lane_q <= pend_lane_d;
            pend_hw_q   <= pend_hw_d;
            end_q       <= end_d;
        end
    end

    ddr_write_slot #(
        .BASE_ADDR(BASE_ADDR)
    ) u_slot (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .load_vld    (ld_vld),
        .load_addr   (word_addr(BASE_ADDR, ld_idx)),
        .load_data   (ld_data),
        .load_mask   (ld_mask),
        .ddr_wait_req(ddr_wait_req),
        .accept      (slot_accept),
        .ddr_wr      (ddr_wr),
        .ddr_addr    (ddr_addr),
        .ddr_din     (ddr_din),
        .ddr_mask    (ddr_mask)
    );

    assign dl_wait = (state_q != FILL);
    assign done    = (state_q == DONE);

`ifdef DOWNLOAD_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (sess_rise) sum_d = '0;
        if (acc_wr) sum_d = sum_d + dl_dout;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_d;
    end

    assign checksum = sum_q;
`else
    logic sess_rise_unused;
    assign sess_rise_unused = sess_rise;
`endif

endmodule

// File: tb/tb_download_packer.sv
// Directed table-driven bench for download_packer.
// Rows: inputs for one cycle plus outputs expected before that edge.
module tb_download_packer;

    localparam logic [31:0] B = 32'h3000_0000;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dl_cs, dl_wr, dl_wait;
    logic [24:0] dl_addr;
    logic [15:0] dl_dout;
    logic        ddr_wr, ddr_wait_req, done;
    logic [31:0] ddr_addr;
    logic [63:0] ddr_din;
    logic [7:0]  ddr_mask;
`ifdef DOWNLOAD_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    download_packer dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .dl_cs       (dl_cs),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_dout     (dl_dout),
        .dl_wait     (dl_wait),
        .ddr_wr      (ddr_wr),
        .ddr_addr    (ddr_addr),
        .ddr_din     (ddr_din),
        .ddr_mask    (ddr_mask),
        .ddr_wait_req(ddr_wait_req),
        .done        (done)
`ifdef DOWNLOAD_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        cs, wr;
        logic [24:0] a;
        logic [15:0] d;
        logic        wq;
        logic        ew, er, ed, cd;
        logic [31:0] ea;
        logic [63:0] ei;
        logic [7:0]  em;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(
        logic cs, logic wr, logic [24:0] a, logic [15:0] d, logic wq,
        logic ew, logic er, logic ed, logic cd,
        logic [31:0] ea, logic [63:0] ei, logic [7:0] em);
        vec_t r;
        r.cs = cs; r.wr = wr; r.a = a; r.d = d; r.wq = wq;
        r.ew = ew; r.er = er; r.ed = ed; r.cd = cd;
        r.ea = ea; r.ei = ei; r.em = em;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive(input logic cs, input logic wr,
                         input logic [24:0] a, input logic [15:0] d,
                         input logic wq);
        dl_cs = cs; dl_wr = wr; dl_addr = a; dl_dout = d;
        ddr_wait_req = wq;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        tick();
        #2 reset = 1'b0;
        tick();

        // full word, lanes 0..3
        v.push_back(mk(1,0,25'h00,16'h0000,0, 0,0,0,1, B,64'h0,8'h00));
        v.push_back(mk(1,1,25'h00,16'h1111,0, 0,0,0,1, B,64'h0,8'h00));
        v.push_back(mk(1,1,25'h02,16'h2222,0, 0,0,0,1, B,64'h0,8'h00));
        v.push_back(mk(1,1,25'h04,16'h3333,0, 0,0,0,1, B,64'h0,8'h00));
        v.push_back(mk(1,1,25'h06,16'h4444,0, 0,0,0,1, B,64'h0,8'h00));
        v.push_back(mk(1,0,25'h00,16'h0000,0, 1,1,0,1, B,
                       64'h4444_3333_2222_1111,8'hFF));
        v.push_back(mk(1,0,25'h00,16'h0000,0, 0,0,0,0, B,64'h0,8'h00));
        // word change goes through pending, then lane 3 completes word 4
        v.push_back(mk(1,1,25'h08,16'hAAAA,0, 0,0,0,0, B,64'h0,8'h00));
        v.push_back(mk(1,1,25'h20,16'hBBBB,0, 0,0,0,0, B,64'h0,8'h00));
        v.push_back(mk(1,0,25'h00,16'h0000,0, 1,1,0,1, B+32'h08,
                       64'h0000_0000_0000_AAAA,8'h03));
        v.push_back(mk(1,1,25'h26,16'hCCCC,0, 0,0,0,0, B,64'h0,8'h00));
        v.push_back(mk(1,0,25'h00,16'h0000,0, 1,1,0,1, B+32'h20,
                       64'hCCCC_0000_0000_BBBB,8'hC3));
        // back-pressure for 5 cycles, dropped write while waiting
        v.push_back(mk(1,1,25'h10,16'h0101,0, 0,0,0,0, B,64'h0,8'h00));
        v.push_back(mk(1,1,25'h12,16'h0202,0, 0,0,0,0, B,64'h0,8'h00));
        v.push_back(mk(1,1,25'h14,16'h0303,0, 0,0,0,0, B,64'h0,8'h00));
        v.push_back(mk(1,1,25'h16,16'h0404,0, 0,0,0,0, B,64'h0,8'h00));
        v.push_back(mk(1,0,25'h00,16'h0000,1, 1,1,0,1, B+32'h10,
                       64'h0404_0303_0202_0101,8'hFF));
        v.push_back(mk(1,1,25'h18,16'hDEAD,1, 1,1,0,1, B+32'h10,
                       64'h0404_0303_0202_0101,8'hFF));
        v.push_back(mk(1,0,25'h00,16'h0000,1, 1,1,0,1, B+32'h10,
                       64'h0404_0303_0202_0101,8'hFF));
        v.push_back(mk(1,0,25'h00,16'h0000,1, 1,1,0,1, B+32'h10,
                       64'h0404_0303_0202_0101,8'hFF));
        v.push_back(mk(1,0,25'h00,16'h0000,1, 1,1,0,1, B+32'h10,
                       64'h0404_0303_0202_0101,8'hFF));
        v.push_back(mk(1,0,25'h00,16'h0000,0, 1,1,0,1, B+32'h10,
                       64'h0404_0303_0202_0101,8'hFF));
        v.push_back(mk(1,0,25'h00,16'h0000,0, 0,0,0,0, B,64'h0,8'h00));
        // single lane-3 write, then session end
        v.push_back(mk(1,1,25'h0E,16'h5A5A,0, 0,0,0,0, B,64'h0,8'h00));
        v.push_back(mk(0,0,25'h00,16'h0000,0, 1,1,0,1, B+32'h08,
                       64'h5A5A_0000_0000_0000,8'hC0));
        v.push_back(mk(0,0,25'h00,16'h0000,0, 1,0,1,0, B,64'h0,8'h00));
        v.push_back(mk(0,0,25'h00,16'h0000,0, 0,0,0,0, B,64'h0,8'h00));
        // write coincident with session end is merged into final flush
        v.push_back(mk(1,0,25'h00,16'h0000,0, 0,0,0,0, B,64'h0,8'h00));
        v.push_back(mk(1,1,25'h32,16'h7777,0, 0,0,0,0, B,64'h0,8'h00));
        v.push_back(mk(0,1,25'h30,16'h8888,0, 0,0,0,0, B,64'h0,8'h00));
        v.push_back(mk(0,0,25'h00,16'h0000,0, 1,1,0,1, B+32'h30,
                       64'h0000_0000_7777_8888,8'h0F));
        v.push_back(mk(0,0,25'h00,16'h0000,0, 1,0,1,0, B,64'h0,8'h00));
        v.push_back(mk(0,0,25'h00,16'h0000,0, 0,0,0,0, B,64'h0,8'h00));
        // empty session end
        v.push_back(mk(1,0,25'h00,16'h0000,0, 0,0,0,0, B,64'h0,8'h00));
        v.push_back(mk(0,0,25'h00,16'h0000,0, 0,0,0,0, B,64'h0,8'h00));
        v.push_back(mk(0,0,25'h00,16'h0000,0, 1,0,1,0, B,64'h0,8'h00));
        v.push_back(mk(0,0,25'h00,16'h0000,0, 0,0,0,0, B,64'h0,8'h00));

        for (int i = 0; i < v.size(); i++) begin
            drive(v[i].cs, v[i].wr, v[i].a, v[i].d, v[i].wq);
            chk($sformatf("row%0d.dl_wait", i), 64'(dl_wait), 64'(v[i].ew));
            chk($sformatf("row%0d.ddr_wr", i), 64'(ddr_wr), 64'(v[i].er));
            chk($sformatf("row%0d.done", i), 64'(done), 64'(v[i].ed));
            if (v[i].cd) begin
                chk($sformatf("row%0d.ddr_addr", i), 64'(ddr_addr),
                    64'(v[i].ea));
                chk($sformatf("row%0d.ddr_din", i), ddr_din, v[i].ei);
                chk($sformatf("row%0d.ddr_mask", i), 64'(ddr_mask),
                    64'(v[i].em));
            end
            tick();
        end

        // reset in the middle of a stalled flush
        drive(1'b1, 1'b1, 25'h00, 16'h0001, 1'b1); tick();
        drive(1'b1, 1'b1, 25'h02, 16'h0002, 1'b1); tick();
        drive(1'b1, 1'b1, 25'h04, 16'h0003, 1'b1); tick();
        drive(1'b1, 1'b1, 25'h06, 16'h0004, 1'b1); tick();
        drive(1'b1, 1'b0, 25'h00, 16'h0000, 1'b1);
        chk("rst.pre_ddr_wr", 64'(ddr_wr), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst.async_ddr_wr", 64'(ddr_wr), 64'd0);
        chk("rst.dl_wait", 64'(dl_wait), 64'd0);
        chk("rst.ddr_addr", 64'(ddr_addr), 64'(B));
        chk("rst.ddr_mask", 64'(ddr_mask), 64'd0);
        #1 reset = 1'b0;
        ddr_wait_req = 1'b0;
        tick();
        chk("rst.no_wr", 64'(ddr_wr), 64'd0);
        drive(1'b1, 1'b1, 25'h00, 16'h9999, 1'b0); tick();
        drive(1'b1, 1'b1, 25'h06, 16'hAAAA, 1'b0); tick();
        drive(1'b1, 1'b0, 25'h00, 16'h0000, 1'b0);
        chk("post.ddr_wr", 64'(ddr_wr), 64'd1);
        chk("post.ddr_addr", 64'(ddr_addr), 64'(B));
        chk("post.ddr_din", ddr_din, 64'hAAAA_0000_0000_9999);
        chk("post.ddr_mask", 64'(ddr_mask), 64'hC3);
        tick();

`ifdef DOWNLOAD_CHECKSUM_EN
        drive(1'b0, 1'b0, 25'h00, 16'h0000, 1'b0); tick();
        drive(1'b1, 1'b0, 25'h00, 16'h0000, 1'b0); tick();
        drive(1'b1, 1'b1, 25'h00, 16'hFFFF, 1'b0); tick();
        drive(1'b1, 1'b1, 25'h02, 16'h0002, 1'b0); tick();
        drive(1'b0, 1'b0, 25'h00, 16'h0000, 1'b0); tick();
        tick();
        chk("csum.done", 64'(done), 64'd1);
        chk("csum.value", 64'(checksum), 64'h0001);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/download_packer.md
DOWNLOAD_PACKER -- requirements
Module: download_packer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, meaning the DDR byte address where download byte offset 0 lands.
REQ-002 SHALL have port clk_sys, input, 1 bit: sole clock; all logic samples on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port dl_cs, input, 1 bit: download session active.
REQ-005 SHALL have port dl_wr, input, 1 bit: halfword write strobe, one cycle per halfword.
REQ-006 SHALL have port dl_addr, input, 25 bits: byte offset of the halfword; bit 0 is ignored.
REQ-007 SHALL have port dl_dout, input, 16 bits: halfword data.
REQ-008 SHALL have port dl_wait, output, 1 bit: back-pressure to the host.
REQ-009 SHALL have port ddr_wr, output, 1 bit: DDR write request.
REQ-010 SHALL have port ddr_addr, output, 32 bits: DDR byte address, 8-byte aligned.
REQ-011 SHALL have port ddr_din, output, 64 bits: DDR write data.
REQ-012 SHALL have port ddr_mask, output, 8 bits: DDR byte enables.
REQ-013 SHALL have port ddr_wait_req, input, 1 bit: DDR busy; a request is accepted on the edge where ddr_wr=1 and ddr_wait_req=0.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when the session has been fully written.

Function
REQ-015 SHALL map each halfword to word index dl_addr[24:3] and lane dl_addr[2:1]; lane n occupies ddr_din[16n+15:16n] and ddr_mask[2n+1:2n].
REQ-016 SHALL use states FILL, FLUSH and DONE.
REQ-017 In FILL, a dl_wr to the held word index, or any dl_wr when the buffer is empty, SHALL merge the data into the buffer and set the lane's two mask bits; rewriting a lane overwrites it.
REQ-018 A write that sets lane 3 SHALL move to FLUSH, with ddr_wr=1 on the next cycle (latency 1).
REQ-019 A dl_wr whose word index differs from a non-empty buffer SHALL be captured into a one-entry pending register and move to FLUSH; after acceptance, the pending entry SHALL seed a fresh buffer.
REQ-020 ddr_addr SHALL equal BASE_ADDR + {word index, 3'b000}, 32-bit wrap-around arithmetic.
REQ-021 In FLUSH, ddr_wr, ddr_addr, ddr_din and ddr_mask SHALL be held stable until acceptance; then the buffer clears and the state returns to FILL (or DONE if the flush was caused by session end).
REQ-022 dl_wait SHALL be high in FLUSH and DONE, otherwise low; dl_wr while dl_wait=1 is a host protocol violation, and such a write is dropped.
REQ-023 A falling edge of dl_cs SHALL flush a partial buffer with only its written lanes masked, then pulse done; with an empty buffer, done SHALL pulse on the next cycle.
REQ-024 DONE SHALL last one cycle, then return to FILL.
REQ-025 dl_wr coincident with the dl_cs falling edge SHALL be merged before the final flush.
REQ-026 Lane-3 completion and a word-index change in the same write SHALL be handled as REQ-019: the old word is flushed and the new halfword goes to pending.

Reset
REQ-027 Reset SHALL force state FILL, empty the buffer and pending register, and drive ddr_wr=0, dl_wait=0, done=0, ddr_mask=0, ddr_din=0 and ddr_addr=BASE_ADDR.
REQ-028 Reset during FLUSH SHALL abandon the request with no further ddr_wr; ddr_wr SHALL deassert asynchronously.

Configuration
REQ-029 With DOWNLOAD_CHECKSUM_EN defined, SHALL add output checksum (16 bits): the modulo-2^16 sum of every accepted dl_dout, cleared on the dl_cs rising edge and on reset, and stable from the done pulse onward.
REQ-030 Without DOWNLOAD_CHECKSUM_EN, the checksum port and its adder SHALL be absent; all other behaviour is identical.

Structure
REQ-031 A shared package SHALL hold the state enum (FILL, FLUSH, DONE), the lane/word-index widths and the default base-address constant.
REQ-032 The DDR request holding register SHALL be a sub-module named ddr_write_slot, with a valid/accept handshake and stable-while-waiting outputs.

Verification
REQ-033 Four writes at addr 0,2,4,6 with data 1111,2222,3333,4444 and ddr_wait_req=0 SHALL produce ddr_wr at the cycle after the fourth write, with ddr_addr=3000_0000, ddr_din=4444_3333_2222_1111 and ddr_mask=FF.
REQ-034 Writes at addr 8 then 0x20 SHALL produce a flush of 3000_0008 with mask 03, followed by a buffer holding lane 0 of word 4.
REQ-035 ddr_wait_req held high for 5 cycles during FLUSH SHALL keep ddr_wr and data stable and dl_wait high, with acceptance at cycle 6.
REQ-036 A single write at addr 0x0E, then a dl_cs fall, SHALL produce a flush with mask C0, then a done pulse one cycle after acceptance.
REQ-037 Reset asserted mid-FLUSH SHALL drop ddr_wr immediately; a post-reset write at addr 0 SHALL start a clean buffer.
REQ-038 With DOWNLOAD_CHECKSUM_EN, writes FFFF and 0002 SHALL yield checksum=0001 at done.
